// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: FSM states and counter widths.
package mem_responder_pkg;

  localparam int unsigned MaskW    = 8;
  localparam int unsigned BeatIdxW = 3;
  // Wide enough to hold WAIT_CYCLES+1 (up to 16) for the inter-beat reload.
  localparam int unsigned WaitCntW = 5;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the core (master) and the memory responder (slave).
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic                req_burst;
  logic [ADDR_W-1:0]   req_addr;
  logic [MaskW-1:0]    req_mask;
  logic [DATA_W-1:0]   req_wdata;
  logic [BeatIdxW-1:0] beat_reg;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_last;
  logic                rsp_err;
  logic                busy;

  modport master (
    output req_valid, req_we, req_burst, req_addr, req_mask, req_wdata,
    input  req_ready, beat_reg, rsp_valid, rsp_rdata, rsp_last, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_burst, req_addr, req_mask, req_wdata,
    output req_ready, beat_reg, rsp_valid, rsp_rdata, rsp_last, rsp_err, busy
  );

endinterface

// File: rtl/mem_responder_lsb_pick.sv
// Lowest-set-bit picker for the burst register mask: index of the next register to serve.
module mem_responder_lsb_pick
  import mem_responder_pkg::*;
(
  input  logic [MaskW-1:0]    mask,
  output logic [BeatIdxW-1:0] idx,
  output logic                any
);

  always_comb begin
    idx = '0;
    for (int i = MaskW - 1; i >= 0; i--) begin
      if (mask[i]) idx = BeatIdxW'(i);
    end
  end

  assign any = |mask;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: single and mask-driven burst accesses to a local array, with
// programmable wait states before each beat and a register-index tag on every beat.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            proc_rst,
  mem_responder_if.slave bus
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WaitCntW-1:0] WaitLoad   = WaitCntW'(WAIT_CYCLES);
  localparam logic [WaitCntW-1:0] WaitReload = WaitCntW'(WAIT_CYCLES + 1);

  state_e              state_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [MaskW-1:0]    mask_q;
  logic [WaitCntW-1:0] wait_cnt_q;
  logic                err_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic                rsp_last_q;
  logic                rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [BeatIdxW-1:0] beat_reg_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [BeatIdxW-1:0] pick_idx;
  logic                pick_any;
  logic [MaskW-1:0]    mask_rest;
  logic [31:0]         addr_ext;
  logic                in_range;
  logic [IdxW-1:0]     mem_idx;

  mem_responder_lsb_pick u_pick (
    .mask (mask_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign mask_rest = pick_any ? (mask_q & ~(MaskW'(1) << pick_idx)) : '0;
  assign addr_ext  = 32'(addr_q);
  assign in_range  = addr_ext < DEPTH;
  assign mem_idx   = addr_q[IdxW-1:0];

  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= '0;
      mask_q      <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      beat_reg_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            addr_q      <= bus.req_addr;
            mask_q      <= bus.req_burst ? bus.req_mask : MaskW'(1);
            wait_cnt_q  <= WaitLoad;
            err_q       <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b0;
            if (bus.req_burst && (bus.req_mask == '0)) begin
              state_q <= StResp;
            end else if (WAIT_CYCLES == 0) begin
              state_q <= StAccess;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (wait_cnt_q <= WaitCntW'(1)) begin
            wait_cnt_q <= '0;
            state_q    <= StAccess;
          end else begin
            wait_cnt_q <= wait_cnt_q - WaitCntW'(1);
          end
        end
        StAccess: begin
          beat_reg_q  <= pick_idx;
          err_q       <= !in_range;
          rsp_rdata_q <= (in_range && !we_q) ? mem[mem_idx] : '0;
          state_q     <= StResp;
        end
        StResp: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          addr_q      <= addr_q + ADDR_W'(1);
          mask_q      <= mask_rest;
          if (mask_rest == '0) begin
            rsp_last_q  <= 1'b1;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            // One extra turnaround cycle between beats on top of the programmed wait.
            wait_cnt_q <= WaitReload;
            state_q    <= StWait;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array contents survive reset; writes happen only while in ACCESS.
  always_ff @(posedge clk) begin
    if ((state_q == StAccess) && in_range && we_q) begin
      mem[mem_idx] <= bus.req_wdata;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = ~req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.beat_reg  = beat_reg_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed and random requests against a queue model.
module tb_mem_responder;

  localparam int unsigned W = 1;

  logic clk = 1'b0;
  logic proc_rst;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(W)) u_dut (
    .clk      (clk),
    .proc_rst (proc_rst),
    .bus      (bus.slave)
  );

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk      (clk),
    .proc_rst (proc_rst),
    .bus      (bus0.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] model_mem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat list from the mask; data for beat on register i is base+i.
  task automatic run_req(input logic we, input logic burst, input logic [15:0] addr,
                         input logic [7:0] mask, input logic [15:0] base, input bit hold,
                         input string tag);
    logic [7:0]  m;
    int          idx[$];
    logic [15:0] a[$];
    logic [15:0] wd[$];
    int          nexp, k, cyc, last_cyc, ready_busy;
    logic [15:0] ak, exp_rd;
    logic        exp_err;
    m = burst ? mask : 8'h01;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        a.push_back(addr + 16'(idx.size()));
        idx.push_back(i);
        wd.push_back(base + 16'(i));
      end
    end
    nexp = (idx.size() == 0) ? 1 : idx.size();
    @(negedge clk);
    chk({tag, ".ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_burst = burst;
    bus.req_addr  = addr;
    bus.req_mask  = mask;
    bus.req_wdata = (idx.size() > 0) ? wd[0] : base;
    @(posedge clk);
    k = 0; cyc = 0; last_cyc = 1; ready_busy = 0;
    while (k < nexp && cyc < 200) begin
      @(negedge clk);
      cyc++;
      // Fields other than wdata must be ignored while busy.
      bus.req_addr  = 16'($urandom);
      bus.req_mask  = 8'($urandom);
      bus.req_we    = 1'($urandom);
      bus.req_burst = 1'($urandom);
      if (!hold) bus.req_valid = 1'b0;
      if (bus.rsp_valid) begin
        exp_rd  = 16'h0;
        exp_err = 1'b0;
        if (idx.size() > 0) begin
          ak      = a[k];
          exp_err = (ak >= 16'd256);
          exp_rd  = (we || exp_err) ? 16'h0 : model_mem[ak[7:0]];
          if (we && !exp_err) model_mem[ak[7:0]] = wd[k];
          chk({tag, ".beat_reg"}, 32'(bus.beat_reg), 32'(idx[k]));
        end
        chk({tag, ".gap"}, 32'(cyc - last_cyc),
            (k > 0) ? 32'(W + 3) : (idx.size() == 0) ? 32'd1 : 32'(W + 2));
        chk({tag, ".last"}, 32'(bus.rsp_last), 32'(k == nexp - 1));
        chk({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_err));
        if (!$isunknown(exp_rd)) chk({tag, ".rdata"}, 32'(bus.rsp_rdata), 32'(exp_rd));
        chk({tag, ".ready_rsp"}, 32'(bus.req_ready), 32'(k == nexp - 1));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(k != nexp - 1));
        last_cyc = cyc;
        k++;
        if (k < idx.size()) bus.req_wdata = wd[k];
        if (k == nexp) bus.req_valid = 1'b0;
      end else if (bus.req_ready) begin
        ready_busy++;
      end
    end
    chk({tag, ".beats"}, 32'(k), 32'(nexp));
    chk({tag, ".ready_while_busy"}, 32'(ready_busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int cyc, pulses, last_cyc;
    for (int i = 0; i < 256; i++) model_mem[i] = 'x;
    proc_rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_burst = 1'b0;
    bus.req_addr = '0; bus.req_mask = '0; bus.req_wdata = '0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_burst = 1'b0;
    bus0.req_addr = '0; bus0.req_mask = '0; bus0.req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(bus.req_ready), 32'd1);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.rsp_last", 32'(bus.rsp_last), 32'd0);
    chk("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst.rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst.beat_reg", 32'(bus.beat_reg), 32'd0);
    proc_rst = 1'b1;

    run_req(1'b1, 1'b0, 16'h0010, 8'h5A, 16'hBEEF, 1'b0, "wr_single");
    run_req(1'b0, 1'b0, 16'h0010, 8'hFF, 16'h0000, 1'b0, "rd_single");

    // Abort a write during its wait state; memory must keep the old value.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_burst = 1'b0;
    bus.req_addr = 16'h0010; bus.req_wdata = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort.busy_before", 32'(bus.busy), 32'd1);
    proc_rst = 1'b0;
    #1;
    chk("abort.ready", 32'(bus.req_ready), 32'd1);
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort.rdata", 32'(bus.rsp_rdata), 32'd0);
    @(negedge clk);
    proc_rst = 1'b1;
    run_req(1'b0, 1'b0, 16'h0010, 8'h00, 16'h0000, 1'b0, "rd_after_abort");

    run_req(1'b1, 1'b1, 16'h0020, 8'h0F, 16'hC000, 1'b0, "prefill");
    run_req(1'b0, 1'b1, 16'h0020, 8'hA5, 16'h0000, 1'b0, "burst_rd");
    run_req(1'b1, 1'b1, 16'h0030, 8'h81, 16'h7700, 1'b0, "burst_wr");
    run_req(1'b0, 1'b1, 16'h0030, 8'h81, 16'h0000, 1'b0, "burst_rb");
    run_req(1'b1, 1'b1, 16'h0010, 8'h00, 16'h5555, 1'b0, "mask0");
    run_req(1'b0, 1'b0, 16'h0010, 8'h00, 16'h0000, 1'b0, "rd_after_mask0");
    run_req(1'b1, 1'b0, 16'h00FF, 8'h00, 16'h4242, 1'b0, "wr_ff");
    run_req(1'b0, 1'b1, 16'h00FF, 8'h03, 16'h0000, 1'b0, "rd_oob");
    run_req(1'b1, 1'b1, 16'h00FE, 8'h07, 16'h9900, 1'b0, "wr_oob");
    run_req(1'b0, 1'b1, 16'hFFFF, 8'h03, 16'h0000, 1'b0, "rd_wrap");
    run_req(1'b0, 1'b1, 16'h0020, 8'h0F, 16'h0000, 1'b1, "hold_valid");

    for (int n = 0; n < 10; n++) begin
      run_req(1'($urandom), 1'($urandom), 16'(32'h00F0 + $urandom_range(0, 31)),
              8'($urandom), 16'($urandom), 1'($urandom), "random");
    end

    // Zero-wait instance: first response 2 edges after accept, beats 3 cycles apart.
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_burst = 1'b1;
    bus0.req_addr = 16'h0050; bus0.req_mask = 8'h07;
    @(posedge clk);
    cyc = 0; pulses = 0; last_cyc = 1;
    while (pulses < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus0.req_valid = 1'b0;
      if (bus0.rsp_valid) begin
        chk("w0.gap", 32'(cyc - last_cyc), (pulses == 0) ? 32'd2 : 32'd3);
        chk("w0.last", 32'(bus0.rsp_last), 32'(pulses == 2));
        last_cyc = cyc;
        pulses++;
      end
    end
    chk("w0.beats", 32'(pulses), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
